// File: rtl/uriscv_tcm_mem_pkg.sv
// Shared widths and defaults for the uriscv tightly-coupled memory.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package uriscv_tcm_mem_pkg;

    localparam int TAG_W      = 11;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int MEM_AW_DEF = 16;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strb_t;

    // Any of these request kinds earns a data-port acknowledge, even the
    // maintenance ones that leave the memory untouched.
    function automatic logic is_data_req(input logic  rd,
                                         input strb_t wr,
                                         input logic  inv,
                                         input logic  wb,
                                         input logic  flush);
        return rd | (|wr) | inv | wb | flush;
    endfunction

endpackage

// File: rtl/uriscv_tcm_mem_if.sv
// Core-side bus bundle: instruction-fetch port plus data port.
// Latency: n/a (wiring only; responses arrive one cycle after requests).
// Backpressure: none, accept lines are tied high by the memory.
interface uriscv_tcm_mem_if;
    import uriscv_tcm_mem_pkg::*;

    // Instruction fetch port
    logic  mem_i_rd_i;
    logic  mem_i_flush_i;
    logic  mem_i_invalidate_i;
    word_t mem_i_pc_i;
    logic  mem_i_accept_o;
    logic  mem_i_valid_o;
    logic  mem_i_error_o;
    word_t mem_i_inst_o;

    // Data port
    word_t mem_d_addr_i;
    word_t mem_d_data_wr_i;
    logic  mem_d_rd_i;
    strb_t mem_d_wr_i;
    logic  mem_d_cacheable_i;
    tag_t  mem_d_req_tag_i;
    logic  mem_d_invalidate_i;
    logic  mem_d_writeback_i;
    logic  mem_d_flush_i;
    logic  mem_d_accept_o;
    logic  mem_d_ack_o;
    word_t mem_d_data_rd_o;
    logic  mem_d_error_o;
    tag_t  mem_d_resp_tag_o;

    modport master (
        output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
        output mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
        output mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_accept_o, mem_d_ack_o, mem_d_data_rd_o, mem_d_error_o,
        input  mem_d_resp_tag_o
    );

    modport slave (
        input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
        input  mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
        input  mem_d_writeback_i, mem_d_flush_i,
        output mem_d_accept_o, mem_d_ack_o, mem_d_data_rd_o, mem_d_error_o,
        output mem_d_resp_tag_o
    );

endinterface

// File: rtl/uriscv_tcm_mem_tcm_ram_dp.sv
// 32-bit dual-port RAM: port A synchronous read, port B synchronous read + byte write.
// Latency: 1 cycle on both ports; read data holds while a port is idle.
// Backpressure: none, one access per port per cycle.
module tcm_ram_dp
    import uriscv_tcm_mem_pkg::*;
#(
    parameter int AW = MEM_AW_DEF - 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_en,
    input  logic [AW-1:0] a_idx,
    output word_t         a_rdat,
    input  logic          b_en,
    input  strb_t         b_we,
    input  logic [AW-1:0] b_idx,
    input  word_t         b_wdat,
    output word_t         b_rdat
);

    localparam int DEPTH = 1 << AW;

    word_t mem [DEPTH];
    word_t a_rdat_q;
    word_t b_rdat_q;

    // Port A: registered read, output cleared by reset and held when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdat_q <= '0;
        end else if (a_en) begin
            a_rdat_q <= mem[a_idx];
        end
    end

    // Port B read: old contents are captured even when the same edge writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_rdat_q <= '0;
        end else if (b_en) begin
            b_rdat_q <= mem[b_idx];
        end
    end

    // Port B byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < STRB_W; n++) begin
            if (b_we[n]) begin
                mem[b_idx][8*n +: 8] <= b_wdat[8*n +: 8];
            end
        end
    end

    assign a_rdat = a_rdat_q;
    assign b_rdat = b_rdat_q;

    // Image-preload path for simulation; never called by the design itself.
    task backdoor_write(input logic [AW-1:0] idx, input int lane, input logic [7:0] data);
        mem[idx][lane*8 +: 8] <= data;
    endtask

endmodule

// File: rtl/uriscv_tcm_mem.sv
// Single-cycle dual-port TCM for the uriscv fetch and data ports, no caches.
// Latency: exactly 1 cycle from request to valid/ack on each port.
// Backpressure: none, accept tied high; one request per port per cycle.
module uriscv_tcm_mem
    import uriscv_tcm_mem_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    uriscv_tcm_mem_if.slave bus
);

    localparam int WORD_AW = MEM_AW - 2;

    logic               i_req;
    logic               d_req;
    strb_t              d_we;
    logic [WORD_AW-1:0] i_idx;
    logic [WORD_AW-1:0] d_idx;
    word_t              i_rdat;
    word_t              d_rdat;

    logic               i_vld_q;
    logic               d_ack_q;
    tag_t               d_tag_q;

    // Request qualification: anything presented during reset is dropped,
    // writes included. Upper address bits alias, the low two select bytes.
    always_comb begin
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = '0;
        i_idx = bus.mem_i_pc_i[MEM_AW-1:2];
        d_idx = bus.mem_d_addr_i[MEM_AW-1:2];
        if (!rst_i) begin
            i_req = bus.mem_i_rd_i;
            d_req = is_data_req(bus.mem_d_rd_i, bus.mem_d_wr_i,
                                bus.mem_d_invalidate_i, bus.mem_d_writeback_i,
                                bus.mem_d_flush_i);
            d_we  = bus.mem_d_wr_i;
        end
    end

    tcm_ram_dp #(
        .AW (WORD_AW)
    ) u_ram (
        .clk    (clk_i),
        .rst    (rst_i),
        .a_en   (i_req),
        .a_idx  (i_idx),
        .a_rdat (i_rdat),
        .b_en   (d_req),
        .b_we   (d_we),
        .b_idx  (d_idx),
        .b_wdat (bus.mem_d_data_wr_i),
        .b_rdat (d_rdat)
    );

    // Response handshake and tag return, one cycle behind the request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_vld_q <= 1'b0;
            d_ack_q <= 1'b0;
            d_tag_q <= '0;
        end else begin
            i_vld_q <= i_req;
            d_ack_q <= d_req;
            if (d_req) begin
                d_tag_q <= bus.mem_d_req_tag_i;
            end
        end
    end

    assign bus.mem_i_accept_o   = 1'b1;
    assign bus.mem_i_error_o    = 1'b0;
    assign bus.mem_i_valid_o    = i_vld_q;
    assign bus.mem_i_inst_o     = i_rdat;

    assign bus.mem_d_accept_o   = 1'b1;
    assign bus.mem_d_error_o    = 1'b0;
    assign bus.mem_d_ack_o      = d_ack_q;
    assign bus.mem_d_data_rd_o  = d_rdat;
    assign bus.mem_d_resp_tag_o = d_tag_q;

    // Inputs the TCM has no use for: no cache to flush, alias bits, byte offset.
    logic unused_inputs;
    assign unused_inputs = ^{bus.mem_i_flush_i, bus.mem_i_invalidate_i,
                             bus.mem_d_cacheable_i,
                             bus.mem_i_pc_i[DATA_W-1:MEM_AW], bus.mem_i_pc_i[1:0],
                             bus.mem_d_addr_i[DATA_W-1:MEM_AW], bus.mem_d_addr_i[1:0]};

    // Byte-granular program preload for simulation, same little-endian mapping.
    task write(input logic [31:0] addr, input logic [7:0] data);
        u_ram.backdoor_write(addr[MEM_AW-1:2], int'(addr[1:0]), data);
    endtask

endmodule

// File: tb/tb_uriscv_tcm_mem.sv
// Randomized + directed bench for uriscv_tcm_mem against a byte-array model.
// Latency: expects every response exactly one cycle after its request.
// Backpressure: none expected; accept must stay high throughout.
module tb_uriscv_tcm_mem;
    import uriscv_tcm_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uriscv_tcm_mem_if bus();

    uriscv_tcm_mem #(.MEM_AW(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural model: flat byte array, 64 KiB, little-endian words.
    logic [7:0] mdl [65536];

    int n_cmp = 0;
    int n_bad = 0;

    logic        exp_valid = 1'b0;
    logic        exp_ack   = 1'b0;
    logic [31:0] exp_inst  = '0;
    logic [31:0] exp_drd   = '0;
    logic [10:0] exp_tag   = '0;
    bit          drd_known = 1'b0;
    bit          tag_chk   = 1'b0;
    bit          chk_en    = 1'b0;

    function automatic logic [31:0] mword(input logic [31:0] a);
        int b;
        b = int'({a[15:2], 2'b00});
        return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic bd_write(input logic [31:0] addr, input logic [7:0] data);
        dut.write(addr, data);
        mdl[addr[15:0]] = data;
    endtask

    // One bus cycle: drive at negedge, derive expectations from the model,
    // then return just after the following rising edge.
    task automatic tick(input bit r, input bit f, input logic [31:0] pc,
                        input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [10:0] tag, input logic [2:0] mnt);
        logic [31:0] noise;
        @(negedge clk);
        noise                  = $urandom;
        rst                    = r;
        bus.mem_i_rd_i         = f;
        bus.mem_i_pc_i         = pc;
        bus.mem_i_flush_i      = noise[0];
        bus.mem_i_invalidate_i = noise[1];
        bus.mem_d_cacheable_i  = noise[2];
        bus.mem_d_rd_i         = rd;
        bus.mem_d_wr_i         = wr;
        bus.mem_d_addr_i       = addr;
        bus.mem_d_data_wr_i    = wd;
        bus.mem_d_req_tag_i    = tag;
        bus.mem_d_invalidate_i = mnt[0];
        bus.mem_d_writeback_i  = mnt[1];
        bus.mem_d_flush_i      = mnt[2];
        if (r) begin
            exp_valid = 1'b0;
            exp_ack   = 1'b0;
            exp_inst  = '0;
            exp_drd   = '0;
            exp_tag   = '0;
            drd_known = 1'b1;
            tag_chk   = 1'b1;
        end else begin
            exp_valid = f;
            if (f) exp_inst = mword(pc);
            exp_ack = rd | (|wr) | (|mnt);
            tag_chk = exp_ack;
            if (exp_ack) exp_tag = tag;
            if (rd) begin
                exp_drd   = mword(addr);
                drd_known = 1'b1;
            end else if (exp_ack) begin
                drd_known = 1'b0;
            end
            for (int n = 0; n < 4; n++)
                if (wr[n]) mdl[{addr[15:2], n[1:0]}] = wd[8*n +: 8];
        end
        chk_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'h0);
    endtask

    // Every-cycle comparison of the DUT against the model's expectations.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("i_accept", {31'b0, bus.mem_i_accept_o}, 32'd1);
            chk("d_accept", {31'b0, bus.mem_d_accept_o}, 32'd1);
            chk("i_error",  {31'b0, bus.mem_i_error_o},  32'd0);
            chk("d_error",  {31'b0, bus.mem_d_error_o},  32'd0);
            chk("i_valid",  {31'b0, bus.mem_i_valid_o},  {31'b0, exp_valid});
            chk("i_inst",   bus.mem_i_inst_o, exp_inst);
            chk("d_ack",    {31'b0, bus.mem_d_ack_o},    {31'b0, exp_ack});
            if (tag_chk)   chk("d_tag", {21'b0, bus.mem_d_resp_tag_o}, {21'b0, exp_tag});
            if (drd_known) chk("d_rdata", bus.mem_d_data_rd_o, exp_drd);
        end
    end

    initial begin
        logic [31:0] ra, rb, rc, pa, da;
        logic [3:0]  wr;

        bus.mem_i_rd_i = 1'b0;        bus.mem_i_pc_i = '0;
        bus.mem_i_flush_i = 1'b0;     bus.mem_i_invalidate_i = 1'b0;
        bus.mem_d_addr_i = '0;        bus.mem_d_data_wr_i = '0;
        bus.mem_d_rd_i = 1'b0;        bus.mem_d_wr_i = '0;
        bus.mem_d_cacheable_i = 1'b0; bus.mem_d_req_tag_i = '0;
        bus.mem_d_invalidate_i = 1'b0; bus.mem_d_writeback_i = 1'b0;
        bus.mem_d_flush_i = 1'b0;

        // Preload the whole array with noise so every read has a defined model value.
        for (int i = 0; i < 65536; i++) begin
            ra = $urandom;
            bd_write(i, ra[7:0]);
        end

        // Reset with fetch, read and full write requests: all must be dropped.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h40, 32'h12345678, 11'h7FF, 3'h0);
            chk("rst_valid",  {31'b0, bus.mem_i_valid_o},  32'd0);
            chk("rst_ack",    {31'b0, bus.mem_d_ack_o},    32'd0);
            chk("rst_iacc",   {31'b0, bus.mem_i_accept_o}, 32'd1);
            chk("rst_dacc",   {31'b0, bus.mem_d_accept_o}, 32'd1);
        end
        idle();

        // Backdoor program image then fetch it.
        bd_write(32'h0, 8'h13); bd_write(32'h1, 8'h00);
        bd_write(32'h2, 8'h00); bd_write(32'h3, 8'h00);
        tick(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'h0);
        chk("bd_valid", {31'b0, bus.mem_i_valid_o}, 32'd1);
        chk("bd_inst",  bus.mem_i_inst_o, 32'h00000013);

        // Full write, then a single-lane overwrite, then tagged read.
        tick(1'b0, 1'b0, 32'h0, 1'b0, 4'b1111, 32'h100, 32'hDEADBEEF, 11'h001, 3'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 4'b0010, 32'h100, 32'h0000AA00, 11'h002, 3'h0);
        chk("mdl_strobe", mword(32'h100), 32'hDEADAAEF);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 11'h5A5, 3'h0);
        chk("strb_ack",  {31'b0, bus.mem_d_ack_o}, 32'd1);
        chk("strb_data", bus.mem_d_data_rd_o, 32'hDEADAAEF);
        chk("strb_tag",  {21'b0, bus.mem_d_resp_tag_o}, 32'h5A5);

        // Back-to-back reads: acks on consecutive cycles.
        tick(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 11'h010, 3'h0);
        chk("b2b_ack0", {31'b0, bus.mem_d_ack_o}, 32'd1);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h104, 32'h0, 11'h011, 3'h0);
        chk("b2b_ack1", {31'b0, bus.mem_d_ack_o}, 32'd1);
        chk("b2b_tag1", {21'b0, bus.mem_d_resp_tag_o}, 32'h011);
        idle();
        chk("idle_ack", {31'b0, bus.mem_d_ack_o}, 32'd0);

        // Fetch and data write to the same word in one cycle: fetch sees old data.
        for (int i = 0; i < 4; i++) bd_write(32'h200 + i, 8'h00);
        tick(1'b0, 1'b1, 32'h200, 1'b0, 4'hF, 32'h200, 32'h11111111, 11'h020, 3'h0);
        chk("coll_old", bus.mem_i_inst_o, 32'h00000000);
        tick(1'b0, 1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'h0);
        chk("coll_new", bus.mem_i_inst_o, 32'h11111111);

        // Address wrap modulo 64 KiB.
        tick(1'b0, 1'b0, 32'h0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 11'h030, 3'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h10000, 32'h0, 11'h031, 3'h0);
        chk("wrap_data", bus.mem_d_data_rd_o, 32'hCAFEF00D);

        // Random traffic in a small window (with random alias bits) for collisions.
        for (int i = 0; i < 3000; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            pa = (ra & 32'hFFFF_0000) | ({27'b0, rb[4:0]} << 2) | {30'b0, ra[1:0]};
            da = (rb & 32'hFFFF_0000) | ({27'b0, rc[4:0]} << 2) | {30'b0, rb[1:0]};
            wr = (rc[7:5] < 3'd3) ? rc[11:8] : 4'h0;
            tick(($urandom_range(0, 63) == 0), rc[12], pa, rc[13], wr, da,
                 $urandom, rc[26:16], (rc[31:29] == 3'd0) ? rc[15:13] : 3'h0);
        end
        idle();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
